// File: rtl/ber_log_regbank.sv
// Host register bank for the PRBS / RC-filter / BER link.
// Drives datapath and log-memory controls, reads back log data and a
// sticky mem-full flag, and holds host-triggered snapshots of the
// per-channel BER sample and error counters.
module ber_log_regbank #(
   parameter int N_CH        = 2,
   parameter int NB_ADDR     = 8,
   parameter int NB_PHASE    = 2,
   parameter int NB_LOG_ADDR = 15,
   parameter int NB_CNT      = 64
) (
   input  logic                      clk,
   input  logic                      i_rst,
   input  logic                      i_wr,
   input  logic                      i_rd,
   input  logic [NB_ADDR-1:0]        i_addr,
   input  logic [31:0]               i_wdata,
   output logic [31:0]               o_rdata,
   output logic                      o_rvalid,
   output logic                      o_rst,
   output logic [1:0]                o_enb,
   output logic [NB_PHASE-1:0]       o_phase_sel,
   output logic                      o_run_log,
   output logic                      o_read_log,
   output logic [NB_LOG_ADDR-1:0]    o_addr_log_to_mem,
   input  logic [31:0]               i_data_log_from_mem,
   input  logic                      i_mem_full,
   input  logic [N_CH*NB_CNT-1:0]    i_ber_samp,
   input  logic [N_CH*NB_CNT-1:0]    i_ber_err
);

   // CTRL layout: [0] soft reset, [2:1] enables, [3 +: NB_PHASE] phase select
   localparam int CTRL_W = 3 + NB_PHASE;

   localparam logic [NB_ADDR-1:0] A_CTRL     = NB_ADDR'(0);
   localparam logic [NB_ADDR-1:0] A_LOG_CMD  = NB_ADDR'(1);
   localparam logic [NB_ADDR-1:0] A_LOG_ADDR = NB_ADDR'(2);
   localparam logic [NB_ADDR-1:0] A_LOG_DATA = NB_ADDR'(3);
   localparam logic [NB_ADDR-1:0] A_STATUS   = NB_ADDR'(4);
   localparam logic [NB_ADDR-1:0] A_SNAP     = NB_ADDR'(5);
   localparam logic [NB_ADDR-1:0] A_CH_BASE  = NB_ADDR'(8);

   logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
   logic                   run_log_q, run_log_d;
   logic                   read_log_q, read_log_d;
   logic [NB_LOG_ADDR-1:0] log_addr_q, log_addr_d;
   logic                   sticky_q, sticky_d;
   logic [NB_CNT-1:0]      samp_q [N_CH];
   logic [NB_CNT-1:0]      samp_d [N_CH];
   logic [NB_CNT-1:0]      err_q  [N_CH];
   logic [NB_CNT-1:0]      err_d  [N_CH];
   logic [31:0]            rdata_q, rdata_d;
   logic                   rvalid_q, rvalid_d;

   logic [31:0]            rd_word;
   logic [NB_ADDR-1:0]     ch_off;
   logic [NB_ADDR-1:0]     ch_idx;

   // Only the low bits of i_wdata are meaningful for most registers
   logic unused_wdata;
   assign unused_wdata = ^i_wdata;

   // Next-state of all host-writable registers; sticky set beats W1C clear
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      ctrl_d     = ctrl_q;
      run_log_d  = 1'b0;
      read_log_d = read_log_q;
      log_addr_d = log_addr_q;
      sticky_d   = sticky_q;
      samp_d     = samp_q;
      err_d      = err_q;
      if (i_wr) begin
         case (i_addr)
            A_CTRL:     ctrl_d = i_wdata[CTRL_W-1:0];
            A_LOG_CMD: begin
               run_log_d  = i_wdata[0];
               read_log_d = i_wdata[1];
            end
            A_LOG_ADDR: log_addr_d = i_wdata[NB_LOG_ADDR-1:0];
            A_STATUS:   if (i_wdata[0]) sticky_d = 1'b0;
            A_SNAP: begin
               for (int c = 0; c < N_CH; c++) begin
                  samp_d[c] = i_ber_samp[c*NB_CNT +: NB_CNT];
                  err_d[c]  = i_ber_err[c*NB_CNT +: NB_CNT];
               end
            end
            default: ;
         endcase
      end
      if (i_mem_full) sticky_d = 1'b1;
   end

   // Read mux over current (pre-write) register contents
   always_comb begin
      rd_word = '0;
      ch_off  = i_addr - A_CH_BASE;
      ch_idx  = {2'b00, ch_off[NB_ADDR-1:2]};
      case (i_addr)
         A_CTRL:     rd_word = 32'(ctrl_q);
         A_LOG_ADDR: rd_word = 32'(log_addr_q);
         A_LOG_DATA: rd_word = i_data_log_from_mem;
         A_STATUS:   rd_word = {29'd0, read_log_q, i_mem_full, sticky_q};
         default: begin
            if (i_addr >= A_CH_BASE) begin
               for (int c = 0; c < N_CH; c++) begin
                  if (ch_idx == NB_ADDR'(c)) begin
                     case (ch_off[1:0])
                        2'd0:    rd_word = samp_q[c][31:0];
                        2'd1:    rd_word = samp_q[c][63:32];
                        2'd2:    rd_word = err_q[c][31:0];
                        default: rd_word = err_q[c][63:32];
                     endcase
                  end
               end
            end
         end
      endcase
      rvalid_d = i_rd;
      rdata_d  = i_rd ? rd_word : rdata_q;
   end

   // State register; reset cancels pending read responses and log pulses
   always_ff @(posedge clk) begin
      if (i_rst) begin
         ctrl_q     <= CTRL_W'(1);
         run_log_q  <= 1'b0;
         read_log_q <= 1'b0;
         log_addr_q <= '0;
         sticky_q   <= 1'b0;
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         // NOTE: snapshots are host-visible registers with a defined reset value, so they are cleared too.
         for (int c = 0; c < N_CH; c++) begin
            samp_q[c] <= '0;
            err_q[c]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         ctrl_q     <= ctrl_d;
         run_log_q  <= run_log_d;
         read_log_q <= read_log_d;
         log_addr_q <= log_addr_d;
         sticky_q   <= sticky_d;
         samp_q     <= samp_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
      end
   end

   assign o_rst             = ctrl_q[0];
   assign o_enb             = ctrl_q[2:1];
   assign o_phase_sel       = ctrl_q[3 +: NB_PHASE];
   assign o_run_log         = run_log_q;
   assign o_read_log        = read_log_q;
   assign o_addr_log_to_mem = log_addr_q;
   assign o_rdata           = rdata_q;
   assign o_rvalid          = rvalid_q;

endmodule

// File: tb/tb_ber_log_regbank.sv
// Self-checking bench for ber_log_regbank: directed table, corner-case
// sequences, then randomized traffic against a behavioural model.
module tb_ber_log_regbank;

   localparam int N_CH        = 2;
   localparam int NB_ADDR     = 8;
   localparam int NB_PHASE    = 2;
   localparam int NB_LOG_ADDR = 15;
   localparam int NB_CNT      = 64;

   logic                      clk = 1'b0;
   logic                      i_rst;
   logic                      i_wr, i_rd;
   logic [NB_ADDR-1:0]        i_addr;
   logic [31:0]               i_wdata;
   logic [31:0]               o_rdata;
   logic                      o_rvalid;
   logic                      o_rst;
   logic [1:0]                o_enb;
   logic [NB_PHASE-1:0]       o_phase_sel;
   logic                      o_run_log;
   logic                      o_read_log;
   logic [NB_LOG_ADDR-1:0]    o_addr_log_to_mem;
   logic [31:0]               i_data_log_from_mem;
   logic                      i_mem_full;
   logic [N_CH*NB_CNT-1:0]    i_ber_samp;
   logic [N_CH*NB_CNT-1:0]    i_ber_err;

   always #5 clk = ~clk;

   ber_log_regbank #(
      .N_CH(N_CH), .NB_ADDR(NB_ADDR), .NB_PHASE(NB_PHASE),
      .NB_LOG_ADDR(NB_LOG_ADDR), .NB_CNT(NB_CNT)
   ) dut (
      .clk                 (clk),
      .i_rst               (i_rst),
      .i_wr                (i_wr),
      .i_rd                (i_rd),
      .i_addr              (i_addr),
      .i_wdata             (i_wdata),
      .o_rdata             (o_rdata),
      .o_rvalid            (o_rvalid),
      .o_rst               (o_rst),
      .o_enb               (o_enb),
      .o_phase_sel         (o_phase_sel),
      .o_run_log           (o_run_log),
      .o_read_log          (o_read_log),
      .o_addr_log_to_mem   (o_addr_log_to_mem),
      .i_data_log_from_mem (i_data_log_from_mem),
      .i_mem_full          (i_mem_full),
      .i_ber_samp          (i_ber_samp),
      .i_ber_err           (i_ber_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [4:0]              m_ctrl;
   bit                      m_read_log;
   logic [NB_LOG_ADDR-1:0]  m_log_addr;
   bit                      m_sticky;
   logic [63:0]             m_samp [N_CH];
   logic [63:0]             m_err  [N_CH];
   logic [31:0]             m_last_rdata;

   task automatic m_reset();
      m_ctrl       = 5'd1;
      m_read_log   = 1'b0;
      m_log_addr   = '0;
      m_sticky     = 1'b0;
      m_last_rdata = '0;
      for (int c = 0; c < N_CH; c++) begin
         m_samp[c] = '0;
         m_err[c]  = '0;
      end
   endtask

   function automatic logic [31:0] m_read(input int a, input bit mem_full, input logic [31:0] log_data);
      int c, k;
      logic [63:0] word64;
      case (a)
         0: return {27'd0, m_ctrl};
         2: return {17'd0, m_log_addr};
         3: return log_data;
         4: return {29'd0, m_read_log, mem_full, m_sticky};
         default: begin
            if (a < 8) return 32'd0;
            c = (a - 8) / 4;
            k = (a - 8) % 4;
            if (c >= N_CH) return 32'd0;
            word64 = (k < 2) ? m_samp[c] : m_err[c];
            return (k % 2 == 0) ? word64[31:0] : word64[63:32];
         end
      endcase
   endfunction

   // One clock cycle of host traffic, checked against the model
   task automatic step(input bit wr, input bit rd, input int addr, input logic [31:0] wdata, input bit mem_full);
      logic [31:0] exp_rd;
      bit          exp_run;
      i_wr = wr; i_rd = rd; i_addr = NB_ADDR'(addr); i_wdata = wdata; i_mem_full = mem_full;
      exp_rd  = m_read(addr, mem_full, i_data_log_from_mem);
      exp_run = wr && (addr == 1) && wdata[0];
      if (wr) begin
         case (addr)
            0: m_ctrl = wdata[4:0];
            1: m_read_log = wdata[1];
            2: m_log_addr = wdata[NB_LOG_ADDR-1:0];
            4: if (wdata[0]) m_sticky = 1'b0;
            5: for (int c = 0; c < N_CH; c++) begin
                  m_samp[c] = i_ber_samp[c*64 +: 64];
                  m_err[c]  = i_ber_err[c*64 +: 64];
               end
            default: ;
         endcase
      end
      if (mem_full) m_sticky = 1'b1;
      if (rd) m_last_rdata = exp_rd;
      @(posedge clk); #1;
      i_wr = 1'b0; i_rd = 1'b0; i_mem_full = 1'b0;
      check("rvalid", o_rvalid, rd);
      check("rdata", o_rdata, m_last_rdata);
      check("run_log", o_run_log, exp_run);
      check("o_rst", o_rst, m_ctrl[0]);
      check("o_enb", o_enb, m_ctrl[2:1]);
      check("phase_sel", o_phase_sel, m_ctrl[4:3]);
      check("read_log", o_read_log, m_read_log);
      check("log_addr", o_addr_log_to_mem, m_log_addr);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      bit          wr;
      bit          rd;
      int          addr;
      logic [31:0] wdata;
      bit          exp_rvalid;
      logic [31:0] exp_rdata;
      bit          exp_rst;
      logic [1:0]  exp_enb;
   } vec_t;

   vec_t tbl [13];

   initial begin
      tbl[0]  = '{wr:0, rd:1, addr:'h00, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'h1,        exp_rst:1, exp_enb:2'b00};
      tbl[1]  = '{wr:1, rd:0, addr:'h00, wdata:32'hE,        exp_rvalid:0, exp_rdata:32'h1,        exp_rst:0, exp_enb:2'b11};
      tbl[2]  = '{wr:0, rd:1, addr:'h00, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'hE,        exp_rst:0, exp_enb:2'b11};
      tbl[3]  = '{wr:1, rd:0, addr:'h02, wdata:32'h1234,     exp_rvalid:0, exp_rdata:32'hE,        exp_rst:0, exp_enb:2'b11};
      tbl[4]  = '{wr:0, rd:1, addr:'h02, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'h1234,     exp_rst:0, exp_enb:2'b11};
      tbl[5]  = '{wr:0, rd:1, addr:'h01, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'h0,        exp_rst:0, exp_enb:2'b11};
      tbl[6]  = '{wr:1, rd:0, addr:'h03, wdata:32'hFFFF,     exp_rvalid:0, exp_rdata:32'h0,        exp_rst:0, exp_enb:2'b11};
      tbl[7]  = '{wr:0, rd:1, addr:'h03, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'hCAFE0003, exp_rst:0, exp_enb:2'b11};
      tbl[8]  = '{wr:0, rd:1, addr:'h10, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'h0,        exp_rst:0, exp_enb:2'b11};
      tbl[9]  = '{wr:1, rd:0, addr:'h00, wdata:32'hFFFFFFE1, exp_rvalid:0, exp_rdata:32'h0,        exp_rst:1, exp_enb:2'b00};
      tbl[10] = '{wr:0, rd:1, addr:'h00, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'h1,        exp_rst:1, exp_enb:2'b00};
      tbl[11] = '{wr:1, rd:0, addr:'h00, wdata:32'hE,        exp_rvalid:0, exp_rdata:32'h1,        exp_rst:0, exp_enb:2'b11};
      tbl[12] = '{wr:0, rd:1, addr:'h04, wdata:32'h0,        exp_rvalid:1, exp_rdata:32'h0,        exp_rst:0, exp_enb:2'b11};

      i_rst = 1'b1; i_wr = 1'b0; i_rd = 1'b0; i_addr = '0; i_wdata = '0;
      i_mem_full = 1'b0; i_data_log_from_mem = 32'hCAFE0003;
      i_ber_samp = '0; i_ber_err = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 i_rst = 1'b0;

      // Reset values
      check("reset_o_rst", o_rst, 1'b1);
      check("reset_o_enb", o_enb, 2'b00);
      check("reset_rvalid", o_rvalid, 1'b0);
      check("reset_rdata", o_rdata, 32'h0);
      check("reset_run_log", o_run_log, 1'b0);
      check("reset_log_addr", o_addr_log_to_mem, '0);

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].wdata, 1'b0);
         check($sformatf("tbl%0d_rvalid", i), o_rvalid, tbl[i].exp_rvalid);
         check($sformatf("tbl%0d_rdata", i), o_rdata, tbl[i].exp_rdata);
         check($sformatf("tbl%0d_rst", i), o_rst, tbl[i].exp_rst);
         check($sformatf("tbl%0d_enb", i), o_enb, tbl[i].exp_enb);
      end
      check("phase_after_0e", o_phase_sel, 2'b01);
      check("log_addr_1234", o_addr_log_to_mem, 15'h1234);

      // Log run pulse lasts exactly one cycle; read_log is a level
      step(1, 0, 1, 32'h1, 0);
      check("run_log_high", o_run_log, 1'b1);
      step(0, 0, 0, 32'h0, 0);
      check("run_log_low", o_run_log, 1'b0);
      step(1, 0, 1, 32'h2, 0);
      check("read_log_set", o_read_log, 1'b1);
      step(0, 0, 0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0);
      check("read_log_held", o_read_log, 1'b1);
      step(0, 1, 4, 32'h0, 0);
      check("status_read_log", o_rdata, 32'h4);

      // Snapshot is frozen against later input changes
      i_ber_samp = '0;
      i_ber_samp[127:64] = 64'h0000_0005_0000_0009;
      i_ber_err = {$urandom, $urandom, $urandom, $urandom};
      step(1, 0, 5, 32'h0, 0);
      i_ber_samp = {$urandom, $urandom, $urandom, $urandom};
      step(0, 1, 'h0C, 32'h0, 0);
      check("snap_ch1_lo", o_rdata, 32'h9);
      step(0, 1, 'h0D, 32'h0, 0);
      check("snap_ch1_hi", o_rdata, 32'h5);
      step(0, 1, 'h08, 32'h0, 0);
      check("snap_ch0_lo", o_rdata, 32'h0);

      // Sticky mem_full with W1C, and set-wins on collision
      step(0, 0, 0, 32'h0, 1);
      step(0, 1, 4, 32'h0, 0);
      check("sticky_set", o_rdata, 32'h5);
      step(1, 0, 4, 32'h1, 0);
      step(0, 1, 4, 32'h0, 0);
      check("sticky_cleared", o_rdata, 32'h4);
      step(1, 0, 4, 32'h1, 1);
      step(0, 1, 4, 32'h0, 0);
      check("sticky_set_wins", o_rdata, 32'h5);
      step(0, 1, 4, 32'h0, 1);
      check("status_live", o_rdata, 32'h7);

      // Simultaneous write and read returns the pre-write value
      step(1, 1, 0, 32'h0, 0);
      check("wr_rd_old", o_rdata, 32'hE);
      step(0, 1, 0, 32'h0, 0);
      check("wr_rd_new", o_rdata, 32'h0);

      // Reset during a pending read and log-run request
      i_rst = 1'b1; i_wr = 1'b1; i_rd = 1'b1; i_addr = 8'h01; i_wdata = 32'h3;
      @(posedge clk); #1;
      i_rst = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
      m_reset();
      check("rst_rvalid", o_rvalid, 1'b0);
      check("rst_run_log", o_run_log, 1'b0);
      check("rst_o_rst", o_rst, 1'b1);
      check("rst_rdata", o_rdata, 32'h0);
      check("rst_read_log", o_read_log, 1'b0);
      step(0, 1, 'h0C, 32'h0, 0);
      check("rst_snap_cleared", o_rdata, 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int a;
         bit wr, rd;
         logic [31:0] wd;
         i_ber_samp = {$urandom, $urandom, $urandom, $urandom};
         i_ber_err  = {$urandom, $urandom, $urandom, $urandom};
         i_data_log_from_mem = $urandom;
         a  = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 23));
         wr = ($urandom_range(0, 9) < 4);
         rd = ($urandom_range(0, 9) < 5);
         wd = $urandom;
         step(wr, rd, a, wd, ($urandom_range(0, 9) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
